// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, active-low syncs, blanked RGB.
// Define VTG_SYNC_CLAMP_EN to clamp sync starts so pulses never wrap a line/frame boundary.
module video_timing_gen #(
  parameter int unsigned H_TOTAL  = 384,
  parameter int unsigned H_START  = 16,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned HS_BASE  = 288,
  parameter int unsigned HS_WIDTH = 32,
  parameter int unsigned H_STEP   = 2,
  parameter int unsigned V_TOTAL  = 264,
  parameter int unsigned V_ACTIVE = 224,
  parameter int unsigned VS_BASE  = 226,
  parameter int unsigned VS_WIDTH = 4,
  parameter int unsigned V_STEP   = 4,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned CW       = 9
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             PCE,
  input  logic [4:0]       HOFFS,
  input  logic [2:0]       VOFFS,
  input  logic [RGB_W-1:0] iRGB,
  output logic [CW-1:0]    HPOS,
  output logic [CW-1:0]    VPOS,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYN,
  output logic             VSYN,
  output logic             FRM,
  output logic [RGB_W-1:0] oRGB
);

  localparam int unsigned AW = CW + 2;

  localparam logic [CW-1:0] HLast   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HStartC = CW'(H_START);

  localparam logic [AW-1:0] HTot    = AW'(H_TOTAL);
  localparam logic [AW-1:0] VTot    = AW'(V_TOTAL);
  localparam logic [AW-1:0] HStart  = AW'(H_START);
  localparam logic [AW-1:0] HEnd    = AW'(H_START + H_ACTIVE);
  localparam logic [AW-1:0] VAct    = AW'(V_ACTIVE);
  localparam logic [AW-1:0] HsBase  = AW'(HS_BASE);
  localparam logic [AW-1:0] HsWidth = AW'(HS_WIDTH);
  localparam logic [AW-1:0] HStep   = AW'(H_STEP);
  localparam logic [AW-1:0] VsBase  = AW'(VS_BASE);
  localparam logic [AW-1:0] VsWidth = AW'(VS_WIDTH);
  localparam logic [AW-1:0] VStep   = AW'(V_STEP);
`ifdef VTG_SYNC_CLAMP_EN
  localparam logic [AW-1:0] HsMax   = AW'(H_TOTAL - HS_WIDTH);
  localparam logic [AW-1:0] VsMax   = AW'(V_TOTAL - VS_WIDTH);
`endif

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [4:0]    hoff_q, hoff_d;
  logic [2:0]    voff_q, voff_d;

  logic [AW-1:0] h_ext, v_ext;
  logic [AW-1:0] hs_raw, vs_raw;
  logic [AW-1:0] hs_b, vs_b;
  logic [AW-1:0] h_rel, v_rel;
  logic          hblk_d, vblk_d, hsyn_d, vsyn_d, frm_d;

  // Next counter values; flags are decoded from these so they line up with the counters.
  always_comb begin
    hcnt_d = hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + CW'(1);
    end
    if (RESET) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
    frm_d  = (hcnt_d == '0) && (vcnt_d == '0);
    // A new frame (or reset) picks up the live offsets for its own sync decode.
    hoff_d = frm_d ? HOFFS : hoff_q;
    voff_d = frm_d ? VOFFS : voff_q;
  end

  always_comb begin
    h_ext  = AW'(hcnt_d);
    v_ext  = AW'(vcnt_d);
    hs_raw = HsBase + AW'(hoff_d) * HStep;
    vs_raw = VsBase + AW'(voff_d) * VStep;
`ifdef VTG_SYNC_CLAMP_EN
    hs_b   = (hs_raw > HsMax) ? HsMax : hs_raw;
    vs_b   = (vs_raw > VsMax) ? VsMax : vs_raw;
`else
    hs_b   = (hs_raw >= HTot) ? hs_raw - HTot : hs_raw;
    vs_b   = (vs_raw >= VTot) ? vs_raw - VTot : vs_raw;
`endif
    // Distance past sync start, wrapped mod total; inside the pulse when below the width.
    h_rel  = (h_ext >= hs_b) ? h_ext - hs_b : h_ext + HTot - hs_b;
    v_rel  = (v_ext >= vs_b) ? v_ext - vs_b : v_ext + VTot - vs_b;
    hsyn_d = (h_rel >= HsWidth);
    vsyn_d = (v_rel >= VsWidth);
    hblk_d = (h_ext < HStart) || (h_ext >= HEnd);
    vblk_d = (v_ext >= VAct);
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hoff_q <= hoff_d;
      voff_q <= voff_d;
      HBLK   <= hblk_d;
      VBLK   <= vblk_d;
      HSYN   <= hsyn_d;
      VSYN   <= vsyn_d;
      FRM    <= frm_d;
      oRGB   <= '0;
    end else if (PCE) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hoff_q <= hoff_d;
      voff_q <= voff_d;
      HBLK   <= hblk_d;
      VBLK   <= vblk_d;
      HSYN   <= hsyn_d;
      VSYN   <= vsyn_d;
      FRM    <= frm_d;
      oRGB   <= (HBLK || VBLK) ? '0 : iRGB;
    end
  end

  assign HPOS = hcnt_q - HStartC;
  assign VPOS = vcnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a reduced raster DUT plus a tall-frame DUT for VSYN wrap.
module tb_video_timing_gen;

  localparam int H_T = 48, H_S = 4, H_A = 32, HS_B = 38, HS_W = 4, H_ST = 1;
  localparam int V_T = 20, V_A = 14, VS_B = 15, VS_W = 2, V_ST = 1;
  localparam int H2_T = 8, V2_T = 232, VS2_B = 226, VS2_W = 4, V2_ST = 4;

  logic        clk;
  logic        rst, pce;
  logic [4:0]  hoffs;
  logic [2:0]  voffs, voffs2;
  logic [11:0] irgb;

  logic [8:0]  hpos, vpos, hpos2, vpos2;
  logic        hblk, vblk, hsyn, vsyn, frm;
  logic        hblk2, vblk2, hsyn2, vsyn2, frm2;
  logic [11:0] orgb, orgb2;

  video_timing_gen #(
    .H_TOTAL(H_T), .H_START(H_S), .H_ACTIVE(H_A), .HS_BASE(HS_B), .HS_WIDTH(HS_W),
    .H_STEP(H_ST), .V_TOTAL(V_T), .V_ACTIVE(V_A), .VS_BASE(VS_B), .VS_WIDTH(VS_W),
    .V_STEP(V_ST), .RGB_W(12), .CW(9)
  ) u_dut (
    .MCLK(clk), .RESET(rst), .PCE(pce), .HOFFS(hoffs), .VOFFS(voffs), .iRGB(irgb),
    .HPOS(hpos), .VPOS(vpos), .HBLK(hblk), .VBLK(vblk), .HSYN(hsyn), .VSYN(vsyn),
    .FRM(frm), .oRGB(orgb)
  );

  video_timing_gen #(
    .H_TOTAL(H2_T), .H_START(1), .H_ACTIVE(4), .HS_BASE(5), .HS_WIDTH(2),
    .H_STEP(1), .V_TOTAL(V2_T), .V_ACTIVE(224), .VS_BASE(VS2_B), .VS_WIDTH(VS2_W),
    .V_STEP(V2_ST), .RGB_W(12), .CW(9)
  ) u_dut_tall (
    .MCLK(clk), .RESET(rst), .PCE(pce), .HOFFS(5'd0), .VOFFS(voffs2), .iRGB(irgb),
    .HPOS(hpos2), .VPOS(vpos2), .HBLK(hblk2), .VBLK(vblk2), .HSYN(hsyn2), .VSYN(vsyn2),
    .FRM(frm2), .oRGB(orgb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        hblk;
    logic        vblk;
    logic        hsyn;
    logic        vsyn;
    logic        frm;
    logic [11:0] rgb;
    logic [8:0]  vpos2;
    logic        vsyn2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state
  int          m_h, m_v, m_hoff, m_voff, m_frames;
  int          m2_h, m2_v;
  logic [11:0] m_rgb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic m_blank(input int h, input int v);
    return (h < H_S) || (h >= H_S + H_A) || (v >= V_A);
  endfunction

  function automatic logic m_hsyn(input int h, input int hoff);
    int b;
    b = HS_B + hoff * H_ST;
`ifdef VTG_SYNC_CLAMP_EN
    if (b > H_T - HS_W) b = H_T - HS_W;
`else
    b = b % H_T;
`endif
    return !(((h - b + H_T) % H_T) < HS_W);
  endfunction

  function automatic logic m_vsyn(input int v, input int voff, input int vtot, input int base,
                                  input int width, input int step);
    int b;
    b = base + voff * step;
`ifdef VTG_SYNC_CLAMP_EN
    if (b > vtot - width) b = vtot - width;
`else
    b = b % vtot;
`endif
    return !(((v - b + vtot) % vtot) < width);
  endfunction

  task automatic model_edge(input logic p, input logic r);
    if (r) begin
      m_h = 0; m_v = 0; m2_h = 0; m2_v = 0;
      m_hoff = int'(hoffs); m_voff = int'(voffs);
      m_rgb = '0; m_frames = 0;
    end else if (p) begin
      m_rgb = m_blank(m_h, m_v) ? 12'h000 : irgb;
      m_h++;
      if (m_h == H_T) begin
        m_h = 0;
        m_v = (m_v + 1) % V_T;
      end
      if (m_h == 0 && m_v == 0) begin
        m_hoff = int'(hoffs);
        m_voff = int'(voffs);
        m_frames++;
      end
      m2_h++;
      if (m2_h == H2_T) begin
        m2_h = 0;
        m2_v = (m2_v + 1) % V2_T;
      end
    end
  endtask

  task automatic step(input logic p, input logic r);
    exp_t e;
    @(negedge clk);
    pce = p;
    rst = r;
    model_edge(p, r);
    e.hpos  = 9'((m_h - H_S + 512) % 512);
    e.vpos  = 9'(m_v);
    e.hblk  = (m_h < H_S) || (m_h >= H_S + H_A);
    e.vblk  = (m_v >= V_A);
    e.hsyn  = m_hsyn(m_h, m_hoff);
    e.vsyn  = m_vsyn(m_v, m_voff, V_T, VS_B, VS_W, V_ST);
    e.frm   = (m_h == 0) && (m_v == 0);
    e.rgb   = m_rgb;
    e.vpos2 = 9'(m2_v);
    e.vsyn2 = m_vsyn(m2_v, 7, V2_T, VS2_B, VS2_W, V2_ST);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("hpos",  32'(hpos),  32'(e.hpos));
    check_eq("vpos",  32'(vpos),  32'(e.vpos));
    check_eq("hblk",  32'(hblk),  32'(e.hblk));
    check_eq("vblk",  32'(vblk),  32'(e.vblk));
    check_eq("hsyn",  32'(hsyn),  32'(e.hsyn));
    check_eq("vsyn",  32'(vsyn),  32'(e.vsyn));
    check_eq("frm",   32'(frm),   32'(e.frm));
    check_eq("orgb",  32'(orgb),  32'(e.rgb));
    check_eq("vpos2", 32'(vpos2), 32'(e.vpos2));
    check_eq("vsyn2", 32'(vsyn2), 32'(e.vsyn2));
  endtask

  task automatic pce_tick();
    repeat (7) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    logic done;
    int   post;
    rst = 1'b1; pce = 1'b0; hoffs = 5'd0; voffs = 3'd0; voffs2 = 3'd7; irgb = 12'hFFF;
    m_h = 0; m_v = 0; m2_h = 0; m2_v = 0; m_hoff = 0; m_voff = 0; m_frames = 0;
    m_rgb = '0;
    done = 1'b0;
    post = 0;

    // Reset held with PCE high: reset must win.
    repeat (3) step(1'b1, 1'b1);

    for (int k = 0; k < 6000 && !done; k++) begin
      if (m_frames >= 1) irgb = 12'($urandom_range(0, 4095));
      if (m_frames == 1 && m_v == 10 && m_h == 0) begin
        hoffs = 5'd31;
        voffs = 3'd7;
      end
      if (m_frames == 2 && m_v == 5 && m_h == 0) hoffs = 5'd20;
      if (m_frames == 2 && m_v == 8 && m_h == 0) hoffs = 5'd31;
      // Offset change on the very edge that wraps to the next frame.
      if (m_frames == 2 && m_v == V_T - 1 && m_h == H_T - 1) begin
        hoffs = 5'd8;
        voffs = 3'd3;
      end
      if (m_frames == 3 && m_v == 4 && m_h == 30) repeat (100) step(1'b0, 1'b0);
      if (m_frames == 3 && m_v == 10 && m_h == 20 && post == 0) begin
        step(1'b0, 1'b1);
        post = 1;
      end
      if (post > 0) begin
        post++;
        if (post > 100) done = 1'b1;
      end
      pce_tick();
    end

    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL schedule: stimulus sequence did not reach its final phase");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade cores: it produces pixel and line counters, blanking flags, active-low syncs and a blanked, registered RGB output. It runs from the core master clock, gated by a pixel-clock enable. User H/V position offsets are double-buffered and take effect only at frame start, so sync never tears mid-frame. It sits between the game core's pixel pipeline (HPOS/VPOS in, colour out) and the scan-converter/video output stage.

## Interface
- H_TOTAL, 384: pixels per line (counter 0..H_TOTAL-1).
- H_START, 16: first active pixel count.
- H_ACTIVE, 256: active pixels per line.
- HS_BASE, 288: HSYN start count at offset 0.
- HS_WIDTH, 32: HSYN width in pixels.
- H_STEP, 2: pixels per HOFFS unit.
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: active lines (lines 0..V_ACTIVE-1).
- VS_BASE, 226: VSYN start line at offset 0.
- VS_WIDTH, 4: VSYN width in lines.
- V_STEP, 4: lines per VOFFS unit.
- RGB_W, 12: colour bus width.
- CW, 9: counter/position width; must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL).

Ports:
- MCLK  in  1  master clock.
- RESET  in  1  synchronous, active-high reset.
- PCE  in  1  pixel-clock enable; all state advances only on MCLK edges with PCE=1.
- HOFFS  in  5  horizontal sync offset, 0..31.
- VOFFS  in  3  vertical sync offset, 0..7.
- iRGB  in  RGB_W  pixel colour from the core.
- HPOS  out  CW  active-relative pixel index, hcnt-H_START mod 2^CW.
- VPOS  out  CW  line index, equal to vcnt.
- HBLK  out  1  high when hcnt is outside [H_START, H_START+H_ACTIVE).
- VBLK  out  1  high when vcnt ≥ V_ACTIVE.
- HSYN  out  1  active-low horizontal sync.
- VSYN  out  1  active-low vertical sync.
- FRM  out  1  high while hcnt=0 and vcnt=0 (one pixel period per frame).
- oRGB  out  RGB_W  registered colour, zero while blanked.

## Operation
- hcnt increments on each PCE. At H_TOTAL-1 it wraps to 0 and vcnt increments. vcnt wraps from V_TOTAL-1 to 0.
- HBLK, VBLK, HSYN, VSYN and FRM are registered. They are computed from the next counter values, so at every cycle they are exact functions of the current hcnt/vcnt. There is no skew against HPOS/VPOS.
- Offset latch: hoff_l/voff_l load HOFFS/VOFFS on the PCE edge that takes the counters to (0,0), and also while RESET=1. Offset changes at any other time have no effect until the next frame.
- Horizontal sync:
  - hs_b = HS_BASE + hoff_l*H_STEP.
  - HSYN=0 for hcnt in [hs_b, hs_b+HS_WIDTH); the window wraps mod H_TOTAL.
- Vertical sync:
  - vs_b = VS_BASE + voff_l*V_STEP.
  - VSYN=0 for vcnt in [vs_b, vs_b+VS_WIDTH); the window wraps mod V_TOTAL.
  - VSYN changes only when hcnt=0, i.e. whole lines.
- Arithmetic is done at CW+2 bits, then reduced mod total (single conditional subtract suffices given the parameter limits).
- On each PCE edge, oRGB <= (HBLK|VBLK) ? 0 : iRGB. HBLK/VBLK here are the values before the update.
- With PCE=0 every register holds.

## Timing
- Reset values: hcnt=0, vcnt=0, HBLK=1, VBLK=0, HSYN=1, VSYN=1, FRM=1, oRGB=0.
  - hcnt=0 < H_START, hence HBLK=1.
  - FRM=1 because the counters sit at (0,0).
  - HSYN/VSYN=1 assumes the defaults; otherwise they are the decoded values at (0,0).
- RESET has priority over PCE. Reset asserted mid-frame restarts at (0,0) on the next MCLK edge.
- Latency:
  - Counters and flags: 0 PCE periods relative to each other.
  - oRGB: 1 PCE period after iRGB.
- Simultaneous frame wrap and offset change: the new offset applies to the frame beginning at that edge.
- The frame is H_TOTAL*V_TOTAL PCE periods (101376 with defaults).

## Configuration
- VTG_SYNC_CLAMP_EN defined:
  - hs_b is clamped to H_TOTAL-HS_WIDTH and vs_b to V_TOTAL-VS_WIDTH.
  - Sync pulses never wrap across a line or frame boundary; an over-range offset pins sync at the end of blanking.
- VTG_SYNC_CLAMP_EN undefined: sync windows wrap mod total as described under Operation.

## Test plan
- Reset, then free-running PCE every 8 MCLK:
  - HBLK low for exactly 256 PCE per line, first at hcnt=16 with HPOS=0.
  - VBLK rises at vcnt=224.
  - FRM period 101376 PCE.
- HOFFS=0, VOFFS=0:
  - HSYN low for hcnt 288..319.
  - VSYN low for lines 226..229.
- Change HOFFS 0→31 mid-frame at vcnt=100:
  - HSYN unchanged until the next FRM.
  - Then low for hcnt 350..381.
- Custom parameters V_TOTAL=232, VS_BASE=226, VOFFS=7 (vs_b=254, reduced mod 232 to 22):
  - Macro undefined: VSYN low for lines 22..25.
  - Macro defined: vs_b clamps to 228, VSYN low for lines 228..231.
- PCE held low 100 cycles mid-line: hcnt, flags and oRGB frozen, with no missed or duplicated pixel.
- iRGB=12'hFFF constant:
  - oRGB=0 whenever HBLK|VBLK was high on the previous PCE.
  - Otherwise 12'hFFF, delayed one PCE.
  - RESET asserted at hcnt=200, vcnt=100 → next edge: hcnt=0, vcnt=0, oRGB=0.
